// File: rtl/ram_port_master_if.sv
// Command, write-stream and read-stream bundle for ram_port_master.
// The master modport belongs to the client issuing bursts. The slave modport
// belongs to ram_port_master.
interface ram_port_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  // burst command
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  // write stream into the RAM
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  // read stream out of the RAM
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/ram_port_master.sv
// ram_port_master: the burst initiator that is the only driver of a
// single-port RAM with combinational read data.
// Write bursts drain the wr stream into consecutive RAM words.
// Read bursts fill the registered rd stream. In both cases the address
// wraps modulo DEPTH.
// Optional build macro RAM_PORT_MASTER_CSUM_EN adds a csum output. It holds
// the running modulo-2^DATA_W sum of the words moved in the current burst.
module ram_port_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_master_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef RAM_PORT_MASTER_CSUM_EN
  ,
  output logic [DATA_W-1:0] csum
`endif
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic              rd_vld_p1;
  logic [DATA_W-1:0] rd_data_p1;

  logic              cmd_fire;
  logic              cmd_bad;
  logic              wr_fire;
  logic              rd_load;
  logic              rd_take;
  logic              cmd_rdy;
  logic              wr_rdy;

  // Address step with wrap at the last implemented word.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] p);
    if ({1'b0, p} >= DEPTH_X - (ADDR_W+1)'(1)) return '0;
    return p + ADDR_W'(1);
  endfunction

  // Handshake qualifiers shared by the FSM and the datapath registers.
  always_comb begin
    cmd_fire = bus.cmd_valid && (state == IDLE);
    cmd_bad  = ({1'b0, bus.cmd_addr} >= DEPTH_X) || ({1'b0, bus.cmd_len} > DEPTH_X);
    wr_fire  = (state == WRITE) && bus.wr_valid;
    rd_take  = (state == READ) && rd_vld_p1 && bus.rd_ready;
    rd_load  = (state == READ) && (remaining != '0) && (!rd_vld_p1 || bus.rd_ready);
  end

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt    = state;
    cmd_rdy      = 1'b0;
    wr_rdy       = 1'b0;
    ram_write_en = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
        if (bus.cmd_valid && !cmd_bad) begin
          if (bus.cmd_len == '0)  state_nxt = DONE;
          else if (bus.cmd_write) state_nxt = WRITE;
          else                    state_nxt = READ;
        end
      end
      WRITE: begin
        wr_rdy       = 1'b1;
        // Gate with rst so no write can slip out during the reset cycle.
        ram_write_en = bus.wr_valid && !rst;
        if (wr_fire && (remaining == ADDR_W'(1))) state_nxt = DONE;
      end
      READ: begin
        if ((remaining == '0) && rd_take) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // Burst pointer, word count, read-output register and reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      remaining  <= '0;
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
      err        <= 1'b0;
    end else begin
      err <= cmd_fire && cmd_bad;
      if (cmd_fire && !cmd_bad) begin
        ptr       <= bus.cmd_addr;
        remaining <= bus.cmd_len;
      end else if (wr_fire || rd_load) begin
        ptr       <= wrap_inc(ptr);
        remaining <= remaining - ADDR_W'(1);
      end
      // ---- stage p1: RAM read word registered toward the consumer ----
      if (rd_load) begin
        rd_data_p1 <= ram_data_out;
        rd_vld_p1  <= 1'b1;
      end else if (rd_take || (state != READ)) begin
        rd_vld_p1  <= 1'b0;
      end
    end
  end

`ifdef RAM_PORT_MASTER_CSUM_EN
  // Modulo-2^DATA_W accumulate: the carry out is dropped on purpose.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Running sum of accepted write words or consumed read words.
  always_ff @(posedge clk) begin
    if (rst)           csum <= '0;
    else if (cmd_fire) csum <= '0;
    else if (wr_fire)  csum <= csum_add(csum, bus.wr_data);
    else if (rd_take)  csum <= csum_add(csum, rd_data_p1);
  end
`endif

  assign ram_addr      = ptr;
  assign ram_data_in   = bus.wr_data;
  assign bus.cmd_ready = cmd_rdy;
  assign bus.wr_ready  = wr_rdy;
  assign bus.rd_valid  = rd_vld_p1;
  assign bus.rd_data   = rd_data_p1;

endmodule
